// File: rtl/halli_galli_pkg.sv
// halli_galli_pkg: shared card types, 7-segment glyphs and game helpers
package halli_galli_pkg;

    typedef enum logic [1:0] {STRAWBERRY, BANANA, LIME, PLUM} fruit_t;

    typedef struct packed {
        logic       valid;
        fruit_t     fruit;
        logic [2:0] count;
    } card_t;

    typedef enum logic {PLAY, OVER} game_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [9:0][6:0] SEG_DIGITS = {
        7'h04, 7'h00, 7'h0F, 7'h20, 7'h24, 7'h4C, 7'h06, 7'h12, 7'h4F, 7'h01
    };

    function automatic logic [6:0] seg_glyph(input logic [3:0] d);
        return (d < 4'd10) ? SEG_DIGITS[d] : SEG_BLANK;
    endfunction

    function automatic logic [2:0] card_rgb(input card_t c);
        return !c.valid ? 3'b000 :
               c.fruit == STRAWBERRY ? 3'b100 :
               c.fruit == BANANA ? 3'b110 :
               c.fruit == LIME ? 3'b010 : 3'b101;
    endfunction

    function automatic card_t draw_card(input logic [4:0] r);
        return '{valid: 1'b1, fruit: fruit_t'(r[1:0]),
                 count: (r[4:2] >= 3'd5) ? r[4:2] - 3'd4 : r[4:2] + 3'd1};
    endfunction

    function automatic logic [3:0] fruit_sum(input card_t a, input card_t b, input fruit_t f);
        return ((a.valid && a.fruit == f) ? {1'b0, a.count} : 4'd0) +
               ((b.valid && b.fruit == f) ? {1'b0, b.count} : 4'd0);
    endfunction

    function automatic logic ring_ok(input card_t a, input card_t b);
        return fruit_sum(a, b, STRAWBERRY) == 4'd5 || fruit_sum(a, b, BANANA) == 4'd5 ||
               fruit_sum(a, b, LIME) == 4'd5 || fruit_sum(a, b, PLUM) == 4'd5;
    endfunction

endpackage

// File: rtl/halli_galli_if.sv
// halli_galli_if: board-side buttons, LEDs and 7-segment lines of the game
interface halli_galli_if;
    logic b1, b2, b3, b4, b5, b6, b7, b8, b9, b10, b11, b12;
    logic led_1_r, led_1_g, led_1_b;
    logic led_2_r, led_2_g, led_2_b;
    logic [6:0] seg_display;
    logic [7:0] seg_position;
    logic l0, l1, l2, l3, l4, l5, l6, l7;

    modport master (
        output b1, b2, b3, b4, b5, b6, b7, b8, b9, b10, b11, b12,
        input  led_1_r, led_1_g, led_1_b, led_2_r, led_2_g, led_2_b,
        input  seg_display, seg_position,
        input  l0, l1, l2, l3, l4, l5, l6, l7
    );

    modport slave (
        input  b1, b2, b3, b4, b5, b6, b7, b8, b9, b10, b11, b12,
        output led_1_r, led_1_g, led_1_b, led_2_r, led_2_g, led_2_b,
        output seg_display, seg_position,
        output l0, l1, l2, l3, l4, l5, l6, l7
    );
endinterface

// File: rtl/halli_galli_seg7_scan.sv
// seg7_scan: multiplexes eight digit codes onto an active-low 7-segment display
module seg7_scan
    import halli_galli_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [7:0][3:0] digits,
    output logic [7:0]      seg_position,
    output logic [6:0]      seg_display
);
    localparam int CW = $clog2(SCAN_DIV + 1);

    logic [CW-1:0] cnt;
    logic [2:0]    idx;

    // hold each digit SCAN_DIV cycles, then step to the next one
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt == CW'(SCAN_DIV - 1)) begin
            cnt <= '0;
            idx <= idx + 3'd1;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign seg_position = ~(8'd1 << idx);
    assign seg_display  = seg_glyph(digits[idx]);
endmodule

// File: rtl/top_halli_galli.sv
// top_halli_galli: two-player Halli Galli game; define HALLI_HINT_EN to light l4 while a ring would be correct
module top_halli_galli
    import halli_galli_pkg::*;
#(
    parameter int          SCAN_DIV   = 50000,
    parameter int          INIT_CARDS = 14,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input logic          clk,
    input logic          rst,
    halli_galli_if.slave hg
);
    logic [4:0]      sync1, sync2, prev, btn_edge;
    logic            clr, ring, flip, bell1, bell2, turn, win1, win2;
    logic [15:0]     lfsr;
    logic [4:0]      deck1, deck2, pile;
    card_t           face1, face2, draw;
    game_state_t     state;
    logic [7:0][3:0] digits;
    logic            unused_buttons;

    assign btn_edge = sync2 & ~prev;
    assign clr      = rst | btn_edge[4];
    assign bell1    = btn_edge[1];
    assign bell2    = btn_edge[3];
    assign flip     = turn ? btn_edge[2] : btn_edge[0];
    assign ring     = ring_ok(face1, face2);
    assign draw     = draw_card(lfsr[4:0]);
    assign unused_buttons = &{1'b0, hg.b6, hg.b7, hg.b8, hg.b9, hg.b10, hg.b11, hg.b12};

    // two-stage synchronizer plus a history stage for rising-edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= {hg.b5, hg.b4, hg.b3, hg.b2, hg.b1};
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    // free-running card RNG, reseeded at every new game
    always_ff @(posedge clk) begin
        if (clr) lfsr <= LFSR_SEED;
        else lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    // game FSM: a bell beats a flip and P1's bell wins a simultaneous ring
    always_ff @(posedge clk) begin
        if (clr) begin
            state <= PLAY;
            turn  <= 1'b0;
            deck1 <= 5'(INIT_CARDS);
            deck2 <= 5'(INIT_CARDS);
            pile  <= '0;
            face1 <= '0;
            face2 <= '0;
            win1  <= 1'b0;
            win2  <= 1'b0;
        end else if (state == PLAY) begin
            if (bell1 || bell2) begin
                if (ring) begin
                    if (bell1) deck1 <= deck1 + pile;
                    else deck2 <= deck2 + pile;
                    pile  <= '0;
                    face1 <= '0;
                    face2 <= '0;
                    turn  <= ~bell1;
                end else if ((bell1 ? deck1 : deck2) == 5'd0) begin
                    state <= OVER;
                    win1  <= ~bell1;
                    win2  <= bell1;
                end else begin
                    deck1 <= bell1 ? deck1 - 5'd1 : deck1 + 5'd1;
                    deck2 <= bell1 ? deck2 + 5'd1 : deck2 - 5'd1;
                end
            end else if (flip) begin
                if ((turn ? deck2 : deck1) == 5'd0) begin
                    state <= OVER;
                    win1  <= turn;
                    win2  <= ~turn;
                end else begin
                    if (turn) begin
                        deck2 <= deck2 - 5'd1;
                        face2 <= draw;
                    end else begin
                        deck1 <= deck1 - 5'd1;
                        face1 <= draw;
                    end
                    pile <= pile + 5'd1;
                    turn <= ~turn;
                end
            end
        end
    end

    assign digits = {4'(deck1 / 5'd10), 4'(deck1 % 5'd10),
                     face1.valid ? {1'b0, face1.count} : 4'hF, 4'hF, 4'hF,
                     face2.valid ? {1'b0, face2.count} : 4'hF,
                     4'(deck2 / 5'd10), 4'(deck2 % 5'd10)};

    assign {hg.led_1_r, hg.led_1_g, hg.led_1_b} = card_rgb(face1);
    assign {hg.led_2_r, hg.led_2_g, hg.led_2_b} = card_rgb(face2);
    assign hg.l0 = state == PLAY && !turn;
    assign hg.l1 = state == PLAY && turn;
    assign hg.l2 = win1;
    assign hg.l3 = win2;
    assign {hg.l7, hg.l6, hg.l5} = (pile > 5'd7) ? 3'd7 : pile[2:0];
`ifdef HALLI_HINT_EN
    assign hg.l4 = ring;
`else
    assign hg.l4 = 1'b0;
`endif

    seg7_scan #(.SCAN_DIV(SCAN_DIV)) u_scan (
        .clk(clk),
        .rst(clr),
        .digits(digits),
        .seg_position(hg.seg_position),
        .seg_display(hg.seg_display)
    );
endmodule

// File: tb/tb_top_halli_galli.sv
// tb_top_halli_galli: scoreboard bench for the Halli Galli top level
module tb_top_halli_galli;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    halli_galli_if hg();

    top_halli_galli #(.SCAN_DIV(1)) dut (.clk(clk), .rst(rst), .hg(hg));

    always #5 clk = ~clk;

    typedef struct { int d1, d2, fc1, fc2, rgb1, rgb2, leds; } exp_t;
    exp_t sb[$];
    int od1, od2, orgb1, orgb2, oleds;

    logic [15:0] m_lfsr;
    logic [4:0]  m_s1, m_s2, m_p;
    int          md[2];
    int          m_pile, m_turn, m_win;
    bit          m_over;
    bit          m_fv[2];
    int          m_ff[2], m_fc[2];

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit m_ring();
        int s;
        for (int f = 0; f < 4; f++) begin
            s = 0;
            for (int p = 0; p < 2; p++) if (m_fv[p] && m_ff[p] == f) s += m_fc[p];
            if (s == 5) return 1'b1;
        end
        return 1'b0;
    endfunction

    // reference game model, stepped on the same clock as the DUT
    always @(posedge clk) begin
        logic [4:0] e;
        int r;
        e = m_s2 & ~m_p;
        if (rst || e[4]) begin
            md = '{14, 14};
            m_pile = 0;
            m_turn = 0;
            m_over = 1'b0;
            m_win = -1;
            m_fv = '{1'b0, 1'b0};
            m_lfsr = 16'hACE1;
        end else begin
            if (!m_over) begin
                if (e[1] || e[3]) begin
                    r = e[1] ? 0 : 1;
                    if (m_ring()) begin
                        md[r] += m_pile;
                        m_pile = 0;
                        m_fv = '{1'b0, 1'b0};
                        m_turn = r;
                    end else if (md[r] == 0) begin
                        m_over = 1'b1;
                        m_win = 1 - r;
                    end else begin
                        md[r]--;
                        md[1-r]++;
                    end
                end else if (e[m_turn == 1 ? 2 : 0]) begin
                    if (md[m_turn] == 0) begin
                        m_over = 1'b1;
                        m_win = 1 - m_turn;
                    end else begin
                        md[m_turn]--;
                        m_pile++;
                        m_fv[m_turn] = 1'b1;
                        m_ff[m_turn] = int'(m_lfsr[1:0]);
                        m_fc[m_turn] = int'(m_lfsr[4:2]) % 5 + 1;
                        m_turn = 1 - m_turn;
                    end
                end
            end
            m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        end
        m_p  = rst ? 5'd0 : m_s2;
        m_s2 = rst ? 5'd0 : m_s1;
        m_s1 = rst ? 5'd0 : {hg.b5, hg.b4, hg.b3, hg.b2, hg.b1};
    end

    function automatic int rgb_exp(input int p);
        if (!m_fv[p]) return 0;
        case (m_ff[p])
            0: return 4;
            1: return 6;
            2: return 2;
            default: return 5;
        endcase
    endfunction

    function automatic int seg_val(input logic [6:0] s);
        case (s)
            7'h01: return 0;
            7'h4F: return 1;
            7'h12: return 2;
            7'h06: return 3;
            7'h4C: return 4;
            7'h24: return 5;
            7'h20: return 6;
            7'h0F: return 7;
            7'h00: return 8;
            7'h04: return 9;
            7'h7F: return 15;
            default: return 99;
        endcase
    endfunction

    task automatic push_exp();
        exp_t e;
        int hint;
`ifdef HALLI_HINT_EN
        hint = int'(m_ring());
`else
        hint = 0;
`endif
        e.d1 = md[0];
        e.d2 = md[1];
        e.fc1 = m_fv[0] ? m_fc[0] : 15;
        e.fc2 = m_fv[1] ? m_fc[1] : 15;
        e.rgb1 = rgb_exp(0);
        e.rgb2 = rgb_exp(1);
        e.leds = (m_pile > 7 ? 7 : m_pile) * 32 + hint * 16 +
                 int'(m_over && m_win == 1) * 8 + int'(m_over && m_win == 0) * 4 +
                 int'(!m_over && m_turn == 1) * 2 + int'(!m_over && m_turn == 0);
        sb.push_back(e);
    endtask

    task automatic observe();
        int dig[8];
        exp_t e;
        foreach (dig[i]) dig[i] = 99;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            for (int k = 0; k < 8; k++)
                if (hg.seg_position == ~(8'd1 << k)) dig[k] = seg_val(hg.seg_display);
        end
        od1 = dig[7] * 10 + dig[6];
        od2 = dig[1] * 10 + dig[0];
        orgb1 = {hg.led_1_r, hg.led_1_g, hg.led_1_b};
        orgb2 = {hg.led_2_r, hg.led_2_g, hg.led_2_b};
        oleds = {hg.l7, hg.l6, hg.l5, hg.l4, hg.l3, hg.l2, hg.l1, hg.l0};
        check("blank_digit4", dig[4], 15);
        check("blank_digit3", dig[3], 15);
        check("sb_depth", sb.size(), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("p1_deck", od1, e.d1);
            check("p2_deck", od2, e.d2);
            check("p1_face", dig[5], e.fc1);
            check("p2_face", dig[2], e.fc2);
            check("p1_rgb", orgb1, e.rgb1);
            check("p2_rgb", orgb2, e.rgb2);
            check("status_leds", oleds, e.leds);
        end
    endtask

    task automatic step(input logic [4:0] m, input int hold);
        @(negedge clk);
        {hg.b5, hg.b4, hg.b3, hg.b2, hg.b1} = m;
        repeat (hold) @(negedge clk);
        {hg.b5, hg.b4, hg.b3, hg.b2, hg.b1} = '0;
        repeat (4) @(negedge clk);
        push_exp();
        observe();
    endtask

    task automatic seek_ring();
        int n;
        n = 0;
        while (!m_ring() && !m_over && n < 28) begin
            step(m_turn == 1 ? 5'b00100 : 5'b00001, 1);
            n++;
        end
        check("ring_found", int'(m_ring()), 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        int exp1, exp2;
        rst = 1'b1;
        {hg.b12, hg.b11, hg.b10, hg.b9, hg.b8, hg.b7, hg.b6} = '0;
        {hg.b5, hg.b4, hg.b3, hg.b2, hg.b1} = '0;
        @(negedge clk);
        check("reset_scan", hg.seg_position, 8'hFE);
        rst = 1'b0;
        push_exp();
        observe();
        check("reset_p1_deck", od1, 14);
        check("reset_p2_deck", od2, 14);
        check("reset_leds", oleds, 8'h01);
        check("reset_rgb1", orgb1, 0);
        check("reset_rgb2", orgb2, 0);

        for (int i = 0; i < 6; i++) begin
            step(5'b00001, 1);
            step(5'b00100, 1);
        end
        check("alt_p1_deck", od1, 8);
        check("alt_p2_deck", od2, 8);
        check("alt_leds", oleds & 8'hEF, 8'hE1);
        check("alt_rgb1_lit", int'(orgb1 != 0), 1);
        check("alt_rgb2_lit", int'(orgb2 != 0), 1);

        step(5'b00100, 1);
        check("off_turn_p2_deck", od2, 8);
        check("off_turn_leds", oleds & 8'h03, 8'h01);
        step(5'b00001, 10);
        check("held_p1_deck", od1, 7);
        check("held_turn", oleds & 8'h03, 8'h02);

        step(5'b10000, 1);
        check("newgame_p1_deck", od1, 14);
        check("newgame_p2_deck", od2, 14);
        seek_ring();
        exp2 = md[1] + m_pile;
        step(5'b01000, 1);
        check("ring_p2_deck", od2, exp2);
        check("ring_leds", oleds & 8'hEF, 8'h02);
        check("ring_rgb1", orgb1, 0);
        check("ring_rgb2", orgb2, 0);

        step(5'b10000, 1);
        step(5'b00010, 1);
        check("wrong_ring_p1", od1, 13);
        check("wrong_ring_p2", od2, 15);
        check("wrong_ring_turn", oleds & 8'h03, 8'h01);
        step(5'b10000, 1);
        seek_ring();
        exp1 = md[0] + m_pile;
        step(5'b01010, 1);
        check("tie_p1_deck", od1, exp1);
        check("tie_turn", oleds & 8'h03, 8'h01);

        step(5'b10000, 1);
        for (int i = 0; i < 14; i++) step(5'b00010, 1);
        check("drain_p1_deck", od1, 0);
        check("drain_p2_deck", od2, 28);
        step(5'b00001, 1);
        check("over_leds", oleds & 8'h0F, 8'h08);
        step(5'b00001, 1);
        step(5'b00100, 1);
        step(5'b00010, 1);
        check("over_p1_deck", od1, 0);
        check("over_p2_deck", od2, 28);
        step(5'b10000, 1);
        check("restart_p1_deck", od1, 14);
        check("restart_p2_deck", od2, 14);
        check("restart_leds", oleds & 8'h0F, 8'h01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/top_halli_galli.md
Name: top_halli_galli

Overview:
Top level of a two-player Halli Galli card game for an FPGA board with 12 push buttons, two RGB LEDs, an 8-digit multiplexed 7-segment display and 8 discrete LEDs.
- Each player has a card tally. On their turn, a player flips a pseudo-random card (fruit plus count 1..5).
- Either player may ring the bell. A ring is correct when the face-up cards of one fruit total exactly 5.
- The block holds the game FSM, card RNG, button edge detection and display drivers.

Parameters:
SCAN_DIV, 50000, clock cycles each 7-seg digit stays selected (must be ≥1)
INIT_CARDS, 14, cards dealt to each player at reset (total 2*INIT_CARDS ≤ 31)
LFSR_SEED, 16'hACE1, RNG reset value (must be nonzero)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
b1  in  1  P1 flip
b2  in  1  P1 bell
b3  in  1  P2 flip
b4  in  1  P2 bell
b5  in  1  new game (same effect as rst)
b6..b12  in  1 each  unused, ignored
led_1_r, led_1_g, led_1_b  out  1 each  P1 face-up fruit colour, active-high
led_2_r, led_2_g, led_2_b  out  1 each  P2 face-up fruit colour, active-high
seg_display  out  7  segments {a,b,c,d,e,f,g}, active-low
seg_position  out  8  digit select, one-hot active-low, bit i = digit i
l0..l7  out  1 each  status LEDs, active-high

Behaviour:
Interface and reset:
- One clock domain. rst is synchronous and active-high.
- Reset values: both decks = INIT_CARDS, pile = 0, no face cards, turn = P1, state PLAY, LFSR = LFSR_SEED, scan index 0 (seg_position = 8'hFE), all RGB LEDs off.
Buttons:
- Each button is registered twice, then rising-edge detected.
- One action per press; a held button acts once. An action takes effect the cycle after the detected edge.
RNG:
- 16-bit Fibonacci LFSR, taps 16,14,13,11, advances every cycle.
- Drawn card: fruit = lfsr[1:0] (0 strawberry, 1 banana, 2 lime, 3 plum); count = (lfsr[4:2] mod 5) + 1.
FSM states: PLAY, OVER.
PLAY, priority per cycle: bell > flip; if both bells fire together, P1 wins the tie.
- Flip by the turn-holder:
  - If that player's deck is 0: go to OVER, opponent wins.
  - Otherwise: deck-1, pile+1, new card replaces the player's face card, turn toggles.
- Flip by the non-turn player: ignored.
- Bell, correct ring: for some fruit, the sum of face-up counts of that fruit equals 5. Ringer deck += pile, pile = 0, both face cards cleared, turn = ringer.
- Bell, wrong ring (includes no face cards): ringer deck-1, opponent deck+1.
  - If the ringer's deck is already 0: go to OVER, opponent wins.
OVER:
- Ignore all buttons except b5.
- b5 or rst returns to the reset state.
RGB colour map (no face card = all off):
- strawberry = R
- banana = R+G
- lime = G
- plum = R+B
7-seg digits:
- 7-6: P1 deck, decimal
- 5: P1 face count
- 2: P2 face count
- 1-0: P2 deck, decimal
- 4-3, and face-count digits with no card: blank (7'h7F)
- Scan order: 0 to 7, wraps, each digit held SCAN_DIV cycles.
Status LEDs:
- l0 = P1 turn, l1 = P2 turn (both 0 in OVER).
- l2 = P1 winner, l3 = P2 winner.
- l7..l5 = pile count, saturating at 7.
Widths:
- Deck and pile counters are 5 bits.
- The sum of deck1, deck2 and pile is invariant at 2*INIT_CARDS.

Optional Feature:
HALLI_HINT_EN:
- Defined: l4 = 1 whenever a correct-ring condition currently holds.
- Undefined: l4 is constant 0 and no hint logic is built.

Decomposition:
- Package halli_galli_pkg holds:
  - fruit enum (2 bits)
  - card struct {valid, fruit, count[2:0]}
  - game-state enum
  - 7-seg glyph constants for 0..9 and blank
- Sub-module seg7_scan: takes 8 digit codes, drives seg_position and seg_display, contains the SCAN_DIV counter and the decoder.

Test Plan:
1. Reset: rst=1 for 1 cycle → l0=1, l1=0, RGB all 0, digits 7-6 and 1-0 show "14" and "14", pile=0.
2. Alternate b1/b3 press (6 each, released between presses) → decks 8/8, pile 12, l0=1, both RGB show nonzero fruit colours.
3. b3 pressed on P1's turn; b1 held for 10 cycles → b3 ignored, exactly one P1 flip registered.
4. Seed chosen so the face cards are (strawberry,2) and (strawberry,3), then b4 → P2 deck = old + pile, pile=0, RGB off, l1=1.
5. b2 with no face cards → P1 deck 13, P2 deck 15, turn unchanged. b2 and b4 in the same cycle under a valid condition → P1 takes the pile.
6. P1 deck exhausted, then b1 → state OVER, l3=1, further flips ignored. b5 → decks back to 14/14.
